// File: rtl/cpld_sidisk_ctrl.sv
// Z80 IO-mapped SRAM "silicon disk": byte pointer registers plus a data port at FEx3.
// Define SIDISK_WAIT_EN to hold the CPU in wait states while the expansion RAM owns the SRAM.
module cpld_sidisk_ctrl (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        iorq_b,
  input  logic        rd_b,
  input  logic        wr_b,
  input  logic        m1_b,
  input  logic [7:0]  adr_hi,
  input  logic [1:0]  adr_lo,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic        mem_busy,
  output logic        sram_sel,
  output logic [18:0] sram_adr,
  output logic        sram_cs_b,
  output logic        sram_oe_b,
  output logic        sram_we_b,
  input  logic [7:0]  sram_din,
  output logic        ready_pd
);

  typedef enum logic [2:0] {IDLE, ARB, ACC1, ACC2, DONE} state_t;

  state_t      state, state_nxt;
  logic [18:0] ptr;
  logic        inc_en;
  logic        err;
  logic        is_read;
  logic        skip;
  logic [7:0]  rdata;
  logic        reg_rd;
  logic [1:0]  reg_sel;

  logic decode, reg_wr, reg_rd_start, port_start, arb_skip, do_inc;

  assign decode       = !iorq_b && m1_b && (adr_hi == 8'hFE);
  // Register writes are held off while the data port is busy so they cannot disturb it.
  assign reg_wr       = decode && !wr_b && (adr_lo != 2'd3) && (state == IDLE);
  assign reg_rd_start = decode && !rd_b && (adr_lo != 2'd3);
  assign port_start   = decode && (adr_lo == 2'd3) && (!rd_b || !wr_b);
`ifdef SIDISK_WAIT_EN
  assign arb_skip     = 1'b0;
`else
  assign arb_skip     = (state == ARB) && !iorq_b && mem_busy;
`endif
  assign do_inc       = (state == DONE) && iorq_b && inc_en && !skip;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: state_nxt gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (port_start) state_nxt = ARB;
      ARB: begin
        if (iorq_b)        state_nxt = IDLE;
        else if (mem_busy) begin
`ifdef SIDISK_WAIT_EN
          state_nxt = ARB;
`else
          state_nxt = DONE;
`endif
        end
        else               state_nxt = ACC1;
      end
      ACC1: state_nxt = iorq_b ? IDLE : ACC2;
      ACC2: state_nxt = iorq_b ? IDLE : DONE;
      DONE: if (iorq_b) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ptr     <= '0;
      inc_en  <= 1'b1;
      err     <= 1'b0;
      is_read <= 1'b0;
      skip    <= 1'b0;
      rdata   <= 8'h00;
      reg_rd  <= 1'b0;
      reg_sel <= 2'd0;
    end else begin
      if ((state == IDLE) && port_start) begin
        is_read <= !rd_b;
        skip    <= 1'b0;
      end
      if ((state == ACC2) && is_read) rdata <= sram_din;
      if (arb_skip) begin
        skip  <= 1'b1;
        rdata <= 8'hFF;
        err   <= 1'b1;
      end

      if (reg_wr) begin
        unique case (adr_lo)
          2'd0: ptr[7:0]  <= data_in;
          2'd1: ptr[15:8] <= data_in;
          2'd2: begin
            inc_en      <= data_in[7];
            err         <= 1'b0;
            ptr[18:16]  <= data_in[2:0];
          end
          default: ;
        endcase
      end else if (do_inc) begin
        ptr <= ptr + 19'd1;
      end

      if (reg_rd_start) begin
        reg_rd  <= 1'b1;
        reg_sel <= adr_lo;
      end else if (iorq_b) begin
        reg_rd  <= 1'b0;
      end
    end
  end

  logic in_acc;
  assign in_acc    = (state == ACC1) || (state == ACC2);
  // A skipped access reaches DONE while the expansion RAM still owns the SRAM.
  assign sram_sel  = in_acc || ((state == DONE) && !skip);
  assign sram_adr  = ptr;
  assign sram_cs_b = !in_acc;
  assign sram_oe_b = !(in_acc && is_read);
  // The strobe is gated by IORQ so an aborting cycle can never commit a write.
  assign sram_we_b = !((state == ACC2) && !is_read && !iorq_b);

`ifdef SIDISK_WAIT_EN
  assign ready_pd  = (state == ARB);
`else
  assign ready_pd  = 1'b0;
`endif

  always_comb begin
    data_oe  = 1'b0;
    data_out = 8'h00;
    if ((state == DONE) && is_read) begin
      data_oe  = 1'b1;
      data_out = rdata;
    end else if (reg_rd) begin
      data_oe = 1'b1;
      unique case (reg_sel)
        2'd0:    data_out = ptr[7:0];
        2'd1:    data_out = ptr[15:8];
        2'd2:    data_out = {inc_en, err, 3'b000, ptr[18:16]};
        default: data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_cpld_sidisk_ctrl.sv
// Directed bench for cpld_sidisk_ctrl: register map, data port, pointer wrap, arbitration, abort, reset.
module tb_cpld_sidisk_ctrl;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        iorq_b = 1'b1, rd_b = 1'b1, wr_b = 1'b1, m1_b = 1'b1;
  logic [7:0]  adr_hi = 8'h00;
  logic [1:0]  adr_lo = 2'd0;
  logic [7:0]  data_in = 8'h00;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        mem_busy = 1'b0;
  logic        sram_sel;
  logic [18:0] sram_adr;
  logic        sram_cs_b, sram_oe_b, sram_we_b;
  logic [7:0]  sram_din;
  logic        ready_pd;

  int tests = 0;
  int fails = 0;

  cpld_sidisk_ctrl dut (
    .clk(clk), .reset_b(reset_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b), .m1_b(m1_b),
    .adr_hi(adr_hi), .adr_lo(adr_lo), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .mem_busy(mem_busy), .sram_sel(sram_sel), .sram_adr(sram_adr), .sram_cs_b(sram_cs_b),
    .sram_oe_b(sram_oe_b), .sram_we_b(sram_we_b), .sram_din(sram_din), .ready_pd(ready_pd)
  );

  always #5 clk = ~clk;

  // SRAM model: 1K window on the low address bits; unwritten bytes read as adr[7:0]^5A.
  logic [7:0] mem [0:1023];
  logic       written [0:1023];
  logic       mem_init = 1'b0;
  int         we_cnt = 0;
  logic [9:0] ma;
  assign ma       = sram_adr[9:0];
  assign sram_din = written[ma] ? mem[ma] : (sram_adr[7:0] ^ 8'h5A);

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
    end else if (!sram_cs_b && !sram_we_b) begin
      mem[ma]     <= data_in;
      written[ma] <= 1'b1;
      we_cnt      <= we_cnt + 1;
    end
  end

  task automatic reg_write(input logic [1:0] lo, input logic [7:0] d);
    @(negedge clk);
    adr_hi = 8'hFE; adr_lo = lo; data_in = d; iorq_b = 1'b0; wr_b = 1'b0;
    @(negedge clk);
    iorq_b = 1'b1; wr_b = 1'b1;
  endtask

  task automatic reg_read(input logic [1:0] lo, output logic [7:0] d, output logic oe);
    @(negedge clk);
    adr_hi = 8'hFE; adr_lo = lo; iorq_b = 1'b0; rd_b = 1'b0;
    @(negedge clk);
    d = data_out; oe = data_oe;
    iorq_b = 1'b1; rd_b = 1'b1;
  endtask

  task automatic get_ptr(output logic [18:0] p);
    logic [7:0] b0, b1, b2;
    logic       oe;
    reg_read(2'd0, b0, oe);
    reg_read(2'd1, b1, oe);
    reg_read(2'd2, b2, oe);
    p = {b2[2:0], b1, b0};
  endtask

  task automatic set_ptr(input logic [18:0] p, input logic inc);
    reg_write(2'd0, p[7:0]);
    reg_write(2'd1, p[15:8]);
    reg_write(2'd2, {inc, 4'b0000, p[18:16]});
  endtask

  task automatic port_write(input logic [7:0] d);
    @(negedge clk);
    adr_hi = 8'hFE; adr_lo = 2'd3; data_in = d; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (6) @(negedge clk);
    iorq_b = 1'b1; wr_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic port_read(output logic [7:0] d, output logic ok);
    @(negedge clk);
    adr_hi = 8'hFE; adr_lo = 2'd3; iorq_b = 1'b0; rd_b = 1'b0;
    ok = 1'b0; d = 8'h00;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (data_oe) begin ok = 1'b1; d = data_out; end
    end
    iorq_b = 1'b1; rd_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string name);
    tests++;
    if ({sram_sel, sram_cs_b, sram_oe_b, sram_we_b, data_oe, ready_pd} !== 6'b011100 ||
        data_out !== 8'h00 || sram_adr !== 19'h0) begin
      fails++;
      $display("FAIL %s: sel/cs/oe/we/doe/rdy=%b data_out=%h adr=%h, required 011100 00 00000", name,
               {sram_sel, sram_cs_b, sram_oe_b, sram_we_b, data_oe, ready_pd}, data_out, sram_adr);
    end
  endtask

  task automatic test_reset;
    logic [7:0]  b;
    logic        oe;
    logic [18:0] p;
    #2;
    check_idle_outputs("reset_outputs");
    repeat (2) @(negedge clk);
    mem_init = 1'b1;
    reset_b  = 1'b1;
    reg_read(2'd2, b, oe);
    tests++;
    if (b !== 8'h80 || oe !== 1'b1) begin
      fails++; $display("FAIL reset_reg2: got %h oe=%b, required 80 oe=1", b, oe);
    end
    get_ptr(p);
    tests++;
    if (p !== 19'h0) begin fails++; $display("FAIL reset_ptr: got %h, required 00000", p); end
  endtask

  task automatic test_registers;
    logic [7:0]  b;
    logic        oe;
    logic [18:0] p;
    reg_write(2'd0, 8'h34);
    reg_write(2'd1, 8'h12);
    reg_write(2'd2, 8'h85);
    reg_read(2'd2, b, oe);
    tests++;
    if (b !== 8'h85 || oe !== 1'b1) begin
      fails++; $display("FAIL reg2_read: got %h oe=%b, required 85 oe=1", b, oe);
    end
    get_ptr(p);
    tests++;
    if (p !== 19'h51234) begin fails++; $display("FAIL ptr_regs: got %h, required 51234", p); end
    @(negedge clk);
    tests++;
    if (data_oe !== 1'b0) begin fails++; $display("FAIL reg_oe_release: got %b, required 0", data_oe); end
  endtask

  task automatic test_port_write_read;
    logic [7:0]  b;
    logic        ok;
    logic [18:0] p;
    set_ptr(19'h00010, 1'b1);
    port_write(8'hAA);
    tests++;
    if (written[10'h010] !== 1'b1 || mem[10'h010] !== 8'hAA) begin
      fails++; $display("FAIL port_write_mem: written=%b data=%h, required 1 AA", written[10'h010], mem[10'h010]);
    end
    port_read(b, ok);
    tests++;
    if (!ok || b !== 8'h4B) begin
      fails++; $display("FAIL port_read_next: got %h ok=%b, required 4B ok=1", b, ok);
    end
    get_ptr(p);
    tests++;
    if (p !== 19'h00012) begin fails++; $display("FAIL ptr_after_two: got %h, required 00012", p); end
  endtask

  task automatic test_wrap;
    logic [7:0]  b;
    logic        ok;
    logic [18:0] p;
    set_ptr(19'h7FFFF, 1'b1);
    port_read(b, ok);
    tests++;
    if (!ok || b !== 8'hA5) begin fails++; $display("FAIL wrap_read: got %h ok=%b, required A5 ok=1", b, ok); end
    get_ptr(p);
    tests++;
    if (p !== 19'h0) begin fails++; $display("FAIL wrap_ptr: got %h, required 00000", p); end
  endtask

  task automatic test_no_increment;
    logic [7:0]  b;
    logic        ok;
    logic [18:0] p;
    set_ptr(19'h00050, 1'b0);
    port_read(b, ok);
    get_ptr(p);
    tests++;
    if (!ok || b !== 8'h0A || p !== 19'h00050) begin
      fails++; $display("FAIL inc_disabled: data=%h ok=%b ptr=%h, required 0A 1 00050", b, ok, p);
    end
  endtask

  task automatic test_busy;
    logic [7:0]  b, r2;
    logic        ok, oe, sel_bad;
    logic [18:0] p;
    int          rdy_cnt;
    set_ptr(19'h00020, 1'b1);
    @(negedge clk);
    mem_busy = 1'b1;
    adr_hi = 8'hFE; adr_lo = 2'd3; iorq_b = 1'b0; rd_b = 1'b0;
    ok = 1'b0; sel_bad = 1'b0; rdy_cnt = 0; b = 8'h00;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (mem_busy && sram_sel) sel_bad = 1'b1;
      if (ready_pd) rdy_cnt++;
      if (data_oe) begin ok = 1'b1; b = data_out; end
`ifdef SIDISK_WAIT_EN
      if (rdy_cnt == 5) mem_busy = 1'b0;
`endif
    end
    iorq_b = 1'b1; rd_b = 1'b1;
    @(negedge clk);
    mem_busy = 1'b0;
    tests++;
    if (sel_bad) begin fails++; $display("FAIL busy_sel: sram_sel=1 while mem_busy, required 0"); end
    reg_read(2'd2, r2, oe);
    get_ptr(p);
`ifdef SIDISK_WAIT_EN
    tests++;
    if (rdy_cnt != 5) begin fails++; $display("FAIL busy_ready: %0d cycles, required 5", rdy_cnt); end
    tests++;
    if (!ok || b !== 8'h7A) begin fails++; $display("FAIL busy_data: got %h ok=%b, required 7A ok=1", b, ok); end
    tests++;
    if (r2 !== 8'h80 || p !== 19'h00021) begin
      fails++; $display("FAIL busy_after: reg2=%h ptr=%h, required 80 00021", r2, p);
    end
`else
    tests++;
    if (rdy_cnt != 0) begin fails++; $display("FAIL busy_ready: %0d cycles, required 0", rdy_cnt); end
    tests++;
    if (!ok || b !== 8'hFF) begin fails++; $display("FAIL busy_data: got %h ok=%b, required FF ok=1", b, ok); end
    tests++;
    if (r2 !== 8'hC0 || p !== 19'h00020) begin
      fails++; $display("FAIL busy_err: reg2=%h ptr=%h, required C0 00020", r2, p);
    end
    reg_write(2'd2, 8'h80);
    reg_read(2'd2, r2, oe);
    tests++;
    if (r2 !== 8'h80) begin fails++; $display("FAIL err_clear: reg2=%h, required 80", r2); end
`endif
  endtask

  task automatic test_abort;
    logic [18:0] p;
    int          we0;
    set_ptr(19'h00030, 1'b1);
    we0 = we_cnt;
    @(negedge clk);
    adr_hi = 8'hFE; adr_lo = 2'd3; data_in = 8'h99; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (2) @(negedge clk);
    iorq_b = 1'b1; wr_b = 1'b1;
    repeat (3) @(negedge clk);
    get_ptr(p);
    tests++;
    if (we_cnt != we0 || written[10'h030] !== 1'b0 || p !== 19'h00030) begin
      fails++; $display("FAIL abort: writes=%0d ptr=%h, required 0 00030", we_cnt - we0, p);
    end
  endtask

  task automatic test_reset_mid_access;
    logic [7:0]  b;
    logic        oe, saw_we;
    logic [18:0] p;
    set_ptr(19'h00040, 1'b0);
    saw_we = 1'b0;
    @(negedge clk);
    adr_hi = 8'hFE; adr_lo = 2'd3; data_in = 8'hEE; iorq_b = 1'b0; wr_b = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (sram_sel !== 1'b1 || sram_cs_b !== 1'b0) begin
      fails++; $display("FAIL mid_acc1: sel=%b cs_b=%b, required 1 0", sram_sel, sram_cs_b);
    end
    reset_b = 1'b0;
    #1;
    check_idle_outputs("mid_reset_outputs");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); if (!sram_we_b) saw_we = 1'b1;
      @(negedge clk); if (!sram_we_b) saw_we = 1'b1;
    end
    iorq_b = 1'b1; wr_b = 1'b1;
    reset_b = 1'b1;
    @(negedge clk);
    tests++;
    if (saw_we || written[10'h040] !== 1'b0) begin
      fails++; $display("FAIL mid_reset_we: we seen=%b written=%b, required 0 0", saw_we, written[10'h040]);
    end
    reg_read(2'd2, b, oe);
    get_ptr(p);
    tests++;
    if (b !== 8'h80 || p !== 19'h0) begin
      fails++; $display("FAIL mid_reset_regs: reg2=%h ptr=%h, required 80 00000", b, p);
    end
  endtask

  initial begin
    test_reset;
    test_registers;
    test_port_write_read;
    test_wrap;
    test_no_increment;
    test_busy;
    test_abort;
    test_reset_mid_access;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
